pipe_chain_sf: RTL and testbench
================================

Name: pipe_chain_sf

Overview:
- Parametrised elastic pipeline register chain; successor to the single enabled flop used between datapath stages.
- Holds STAGES slots of N-bit data, each with its own valid bit, joined by valid/ready handshakes.
- Supports stall back-pressure, bubble collapsing, a global flush and an occupancy count.
- Sits between processor pipeline stages (e.g. IF/ID, ID/EX) where hazard logic must stall or squash in-flight instructions.

Parameters:
- N, 64, data width in bits (≥1).
- STAGES, 2, number of register slots in the chain (≥1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- flush  input  1  squash all in-flight entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  N  upstream payload.
- out_valid  output  1  last slot holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  N  payload of last slot.
- occupancy  output  $clog2(STAGES+1)  number of valid slots.

Behaviour:
- **State per slot i (0 = input end, STAGES-1 = output end):** v[i], d[i].
- **Reset** (reset=1 at posedge): all v=0, all d=0, occupancy=0.
  - Reset overrides flush and all handshakes.
  - Outputs after reset: out_valid=0, in_ready=1, out_data=0.
- **Transfers:** input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. Both may occur in the same cycle.
- **Advance rule** (adv[i] = slot i may load from its upstream this cycle):
  - adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - adv[i] = !v[i] || adv[i+1], for i < STAGES-1.
  - The ready chain is combinational. Full throughput (one transfer per cycle) holds when out_ready=1.
- **in_ready:** equals adv[0] && !flush.
- **On adv[i]:**
  - v[i] <= upstream valid, where upstream is in_valid for i=0, else v[i-1].
  - d[i] <= upstream data, only when upstream valid=1. Otherwise d[i] is held.
- **On !adv[i]:** slot i holds v and d.
- **Bubble collapse:** an empty slot is filled even while downstream slots are stalled.
- **Latency:** an entry accepted at cycle t with no stalls appears on out_valid at cycle t+STAGES.
- **Order:** strictly FIFO. No duplication, no loss except on flush.
- **out_data / out_valid:** out_data = d[STAGES-1]; out_valid = v[STAGES-1] && !flush.
- **flush=1 (and reset=0):**
  - Next cycle all v=0 and occupancy=0.
  - No input or output transfer occurs in the flush cycle: in_ready=0, out_valid=0.
  - d is retained unless the optional feature is enabled.
- **occupancy:** registered counter.
  - +1 on input transfer only; -1 on output transfer only; unchanged when both or neither occur.
  - Forced to 0 on flush or reset.
  - Must always equal popcount(v).
  - Saturation cannot occur: in_ready=0 when all slots are full and out_ready=0.
- **Full:** all v=1 and out_ready=0 → in_ready=0, nothing moves.
- **Empty:** out_valid=0. out_ready is a don't-care.
- **STAGES=1:** behaves as a single slot with in_ready = (!v[0] || out_ready) && !flush.

Optional Feature:
- Macro: PIPE_FLUSH_ZERO_EN.
- Defined:
  - flush also clears every d[i] to 0 on the next posedge.
  - out_data is driven 0 whenever out_valid=0.
- Undefined:
  - flush clears only valid bits; data registers keep stale values.
  - out_data always shows d[STAGES-1].

Test Plan (N=64, STAGES=3):
- **Reset:** reset=1 for 2 cycles with in_valid=1 → out_valid=0, occupancy=0, out_data=0, in_ready=1 after release.
- **Streaming:** out_ready=1; push 0x1,0x2,0x3,0x4 on consecutive cycles → out_data 0x1..0x4 appear on cycles 3..6 after the first push, one per cycle, occupancy steady at 3.
- **Back-pressure:** out_ready=0; push 0xA,0xB,0xC,0xD → 0xA..0xC accepted, in_ready=0 on 4th push, occupancy=3. Raise out_ready → 0xA,0xB,0xC,0xD delivered in order, 0xD accepted the same cycle out_ready rises.
- **Bubble collapse:** out_ready=0; push 0x5, idle 2 cycles, push 0x6 → 0x6 settles in slot 1 adjacent to 0x5, occupancy=2, no gap on drain.
- **Flush:** chain holds 0x7,0x8, flush=1 with in_valid=1 and out_ready=1 → no transfer that cycle, next cycle out_valid=0, occupancy=0. With PIPE_FLUSH_ZERO_EN, out_data=0.
- **Simultaneous events:** full chain, out_ready=1 and in_valid=1 in the same cycle → occupancy stays 3. Asserting reset mid-stream clears everything on the next posedge regardless of flush and handshakes.

Source files
------------

// File: rtl/pipe_chain_sf_if.sv
// Valid/ready handshake bundle for pipe_chain_sf: an upstream push side and a downstream pop side.
interface pipe_chain_sf_if #(
  parameter int unsigned N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_chain_sf.sv
// Elastic register chain of STAGES valid-tagged slots with stall, bubble collapse, flush and occupancy.
// Define PIPE_FLUSH_ZERO_EN to zero all data on flush and to drive out_data to 0 while out_valid is low.
module pipe_chain_sf #(
  parameter  int unsigned N      = 64,
  parameter  int unsigned STAGES = 2,
  localparam int unsigned OCC_W  = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_chain_sf_if.slave     bus,
  output logic [OCC_W-1:0]   occupancy
);

  logic [STAGES-1:0] v;
  logic [N-1:0]      d [STAGES];

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] up_v;
  logic [N-1:0]      up_d [STAGES];
  logic              all_full_c;
  logic              in_xfer;
  logic              out_xfer;

  // A slot may load when it or any slot downstream of it has room, or the sink drains.
  always_comb begin
    adv        = '0;
    all_full_c = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      all_full_c = all_full_c & v[i];
      adv[i]     = bus.out_ready | ~all_full_c;
    end
  end

  // Upstream source of each slot: the chain input for slot 0, else the previous slot.
  always_comb begin
    up_v    = '0;
    up_v[0] = bus.in_valid;
    up_d[0] = bus.in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  assign bus.in_ready  = adv[0] & ~flush;
  assign bus.out_valid = v[STAGES-1] & ~flush;

`ifdef PIPE_FLUSH_ZERO_EN
  assign bus.out_data = bus.out_valid ? d[STAGES-1] : '0;
`else
  assign bus.out_data = d[STAGES-1];
`endif

  assign in_xfer  = bus.in_valid  & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  // Slot state: reset beats flush, flush beats every handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
`ifdef PIPE_FLUSH_ZERO_EN
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
      end
`endif
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) begin
            d[i] <= up_d[i];
          end
        end
      end
    end
  end

  // Occupancy tracks popcount(v) incrementally from the two transfer strobes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_chain_sf.sv
// Self-checking bench for pipe_chain_sf (N=64, STAGES=3): directed scenarios then random traffic vs a queue model.
module tb_pipe_chain_sf;
  localparam int unsigned N      = 64;
  localparam int unsigned STAGES = 3;
  localparam int unsigned OCC_W  = $clog2(STAGES + 1);

  logic             clk;
  logic             reset;
  logic             flush;
  logic [OCC_W-1:0] occupancy;

  pipe_chain_sf_if #(.N(N)) bus ();

  pipe_chain_sf #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-flight entries oldest first, each tagged with the slot it sits in.
  typedef struct {
    logic [N-1:0] data;
    int           pos;
  } ent_t;

  ent_t         q[$];
  logic [N-1:0] last_d;
  int           n_tests;
  int           n_fail;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [N-1:0] id, input logic ordy);
    logic         exp_ir;
    logic         exp_ov;
    logic [N-1:0] exp_od;
    logic         in_x;
    logic         out_x;
    int           lim;
    int           np;
    ent_t         e;

    @(negedge clk);
    reset         = rst;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;

    exp_ir = !fl && ((q.size() < STAGES) || ordy);
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = !fl && (q[0].pos == STAGES - 1);
`ifdef PIPE_FLUSH_ZERO_EN
    exp_od = exp_ov ? last_d : '0;
`else
    exp_od = last_d;
`endif

    check("in_ready",  N'(bus.in_ready),  N'(exp_ir));
    check("out_valid", N'(bus.out_valid), N'(exp_ov));
    check("out_data",  bus.out_data,      exp_od);
    check("occupancy", N'(occupancy),     N'(q.size()));

    if (rst) begin
      q.delete();
      last_d = '0;
    end else if (fl) begin
      q.delete();
`ifdef PIPE_FLUSH_ZERO_EN
      last_d = '0;
`endif
    end else begin
      in_x  = iv && exp_ir;
      out_x = exp_ov && ordy;
      if (out_x) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        lim = (i == 0) ? int'(STAGES) - 1 : q[i-1].pos - 1;
        e   = q[i];
        np  = (e.pos + 1 < lim) ? e.pos + 1 : lim;
        if (np != e.pos && np == int'(STAGES) - 1) last_d = e.data;
        e.pos = np;
        q[i]  = e;
      end
      if (in_x) begin
        e.data = id;
        e.pos  = 0;
        q.push_back(e);
        if (STAGES == 1) last_d = id;
      end
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, ordy);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hDEAD;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    last_d = '0;

    // Reset held with traffic offered.
    step(1'b1, 1'b0, 1'b1, 64'h55, 1'b1);
    idle(1'b1, 1);

    // Streaming.
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b1, N'(k), 1'b1);
    idle(1'b1, 4);

    // Back-pressure then release with D accepted as ready rises.
    step(1'b0, 1'b0, 1'b1, 64'hA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'hB, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'hC, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'hD, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'hD, 1'b1);
    idle(1'b1, 4);

    // Bubble collapse.
    step(1'b0, 1'b0, 1'b1, 64'h5, 1'b0);
    idle(1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 64'h6, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 3);

    // Flush with handshakes asserted.
    step(1'b0, 1'b0, 1'b1, 64'h7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h8, 1'b0);
    idle(1'b0, 2);
    step(1'b0, 1'b1, 1'b1, 64'h9, 1'b1);
    idle(1'b1, 2);

    // Full chain with simultaneous push and pop, then reset mid-stream.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, N'(64'h20 + k), 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h30, 1'b1);
    step(1'b0, 1'b0, 1'b1, 64'h31, 1'b1);
    step(1'b1, 1'b1, 1'b1, 64'h32, 1'b1);
    idle(1'b1, 2);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step(1'b0 == ($urandom_range(199) != 0) ? 1'b1 : 1'b0,
           $urandom_range(39) == 0,
           $urandom_range(9) < 7,
           {$urandom, $urandom},
           $urandom_range(9) < 6);
    end
    idle(1'b1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
